instr_fetch: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter in the 8-bit core. Reads the current PC, fetches the 8-bit instruction from instruction memory over a req/ack handshake, and holds it in an instruction register for the execute stage under a valid/ready handshake. On hand-off it drives the PC's step strobe, `offset_bit` and `addr_in` offset, so the PC either increments or takes a PC-relative branch.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/branch_decode.sv | 26 ++
 rtl/instr_fetch.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage of the 8-bit core.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;

  // Top two instruction bits equal to this value mark a PC-relative branch.
  localparam logic [1:0] OP_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    STEP  = 2'd3
  } fetch_state_e;

  // True when the opcode field selects a branch.
  function automatic logic is_branch_op(input logic [1:0] op);
    return (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/branch_decode.sv
// Combinational decode of the held instruction: branch flag and the
// sign-extended low immediate, widened to the PC address width.
module branch_decode
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic [DATA_W-1:0] ir_data,
  output logic              is_branch,
  output logic [ADDR_W-1:0] offset
);

  localparam int IMM_W = DATA_W - 2;

  logic [IMM_W-1:0] imm_s;

  assign imm_s = ir_data[IMM_W-1:0];

  // Classify the opcode and sign-extend the immediate field.
  always_comb begin
    is_branch = is_branch_op(ir_data[DATA_W-1 -: 2]);
    offset    = {{(ADDR_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads the PC, fetches one instruction over a
// req/ack memory handshake, holds it for execute under valid/ready, then
// strobes the PC to increment or take a PC-relative branch.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              CLK,
  input  logic              areset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              flush,
  output logic              pc_step,
  output logic              offset_bit,
  output logic [ADDR_W-1:0] offset
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;

  // Set when a flush lands on an outstanding request; its data must be dropped.
  logic discard_r;
  logic discard_nxt_s;

  logic              mem_req_r,    mem_req_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r,   mem_addr_nxt_s;
  logic              ir_valid_r,   ir_valid_nxt_s;
  logic [DATA_W-1:0] ir_data_r,    ir_data_nxt_s;
  logic [ADDR_W-1:0] ir_pc_r,      ir_pc_nxt_s;
  logic              pc_step_r,    pc_step_nxt_s;
  logic              offset_bit_r, offset_bit_nxt_s;
  logic [ADDR_W-1:0] offset_r,     offset_nxt_s;

  logic              dec_branch_s;
  logic [ADDR_W-1:0] dec_offset_s;

  branch_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_branch_decode (
    .ir_data   (ir_data_r),
    .is_branch (dec_branch_s),
    .offset    (dec_offset_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_nxt_s      = state_r;
    discard_nxt_s    = discard_r;
    mem_req_nxt_s    = mem_req_r;
    mem_addr_nxt_s   = mem_addr_r;
    ir_valid_nxt_s   = ir_valid_r;
    ir_data_nxt_s    = ir_data_r;
    ir_pc_nxt_s      = ir_pc_r;
    pc_step_nxt_s    = 1'b0;
    offset_bit_nxt_s = 1'b0;
    offset_nxt_s     = {ADDR_W{1'b0}};

    case (state_r)
      IDLE: begin
        // One settling cycle for the PC, then the first request.
        state_nxt_s    = FETCH;
        mem_req_nxt_s  = 1'b1;
        mem_addr_nxt_s = pc_addr;
        discard_nxt_s  = 1'b0;
      end

      FETCH: begin
        if (mem_ack) begin
          if (discard_r || flush) begin
            // Drop the flushed word and re-request from the current PC.
            state_nxt_s    = FETCH;
            mem_req_nxt_s  = 1'b1;
            mem_addr_nxt_s = pc_addr;
            discard_nxt_s  = 1'b0;
          end else begin
            state_nxt_s    = HOLD;
            mem_req_nxt_s  = 1'b0;
            ir_valid_nxt_s = 1'b1;
            ir_data_nxt_s  = mem_rdata;
            ir_pc_nxt_s    = mem_addr_r;
            discard_nxt_s  = 1'b0;
          end
        end else if (flush) begin
          // The request cannot be withdrawn; remember to ignore its answer.
          discard_nxt_s = 1'b1;
        end else begin
          discard_nxt_s = discard_r;
        end
      end

      HOLD: begin
        if (flush) begin
          // Flush beats ready: no PC step, refetch the same address.
          state_nxt_s    = FETCH;
          ir_valid_nxt_s = 1'b0;
          mem_req_nxt_s  = 1'b1;
          mem_addr_nxt_s = pc_addr;
          discard_nxt_s  = 1'b0;
        end else if (ir_valid_r && ir_ready) begin
          state_nxt_s      = STEP;
          ir_valid_nxt_s   = 1'b0;
          pc_step_nxt_s    = 1'b1;
          offset_bit_nxt_s = dec_branch_s;
          offset_nxt_s     = dec_branch_s ? dec_offset_s : {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = HOLD;
        end
      end

      STEP: begin
        // The PC moved on the falling edge; sample its new value here.
        state_nxt_s    = FETCH;
        mem_req_nxt_s  = 1'b1;
        mem_addr_nxt_s = pc_addr;
        discard_nxt_s  = 1'b0;
      end

      default: begin
        state_nxt_s    = IDLE;
        mem_req_nxt_s  = 1'b0;
        ir_valid_nxt_s = 1'b0;
        discard_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers; reset clears every output.
  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      discard_r    <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      ir_valid_r   <= 1'b0;
      ir_data_r    <= {DATA_W{1'b0}};
      ir_pc_r      <= {ADDR_W{1'b0}};
      pc_step_r    <= 1'b0;
      offset_bit_r <= 1'b0;
      offset_r     <= {ADDR_W{1'b0}};
    end else begin
      discard_r    <= discard_nxt_s;
      mem_req_r    <= mem_req_nxt_s;
      mem_addr_r   <= mem_addr_nxt_s;
      ir_valid_r   <= ir_valid_nxt_s;
      ir_data_r    <= ir_data_nxt_s;
      ir_pc_r      <= ir_pc_nxt_s;
      pc_step_r    <= pc_step_nxt_s;
      offset_bit_r <= offset_bit_nxt_s;
      offset_r     <= offset_nxt_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign ir_valid   = ir_valid_r;
  assign ir_data    = ir_data_r;
  assign ir_pc      = ir_pc_r;
  assign pc_step    = pc_step_r;
  assign offset_bit = offset_bit_r;
  assign offset     = offset_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, directed corner
// sequences, and a randomized run against a transaction-level model.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       areset;
  logic [7:0] pc_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       ir_valid;
  logic [7:0] ir_data;
  logic [7:0] ir_pc;
  logic       ir_ready;
  logic       flush;
  logic       pc_step;
  logic       offset_bit;
  logic [7:0] offset;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(.ADDR_W(8), .DATA_W(8)) dut (
    .CLK        (clk),
    .areset     (areset),
    .pc_addr    (pc_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir_valid   (ir_valid),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc),
    .ir_ready   (ir_ready),
    .flush      (flush),
    .pc_step    (pc_step),
    .offset_bit (offset_bit),
    .offset     (offset)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"},    32'(mem_req),    32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_ir_valid"},   32'(ir_valid),   32'd0);
    chk({tag, "_ir_data"},    32'(ir_data),    32'd0);
    chk({tag, "_ir_pc"},      32'(ir_pc),      32'd0);
    chk({tag, "_pc_step"},    32'(pc_step),    32'd0);
    chk({tag, "_offset_bit"}, 32'(offset_bit), 32'd0);
    chk({tag, "_offset"},     32'(offset),     32'd0);
  endtask

  // Reference decode from the instruction set rules, in plain arithmetic.
  function automatic logic ref_branch(input logic [7:0] ins);
    return (ins >= 8'hC0);
  endfunction

  function automatic logic [7:0] ref_offset(input logic [7:0] ins);
    int v;
    if (ins < 8'hC0) return 8'h00;
    v = int'(ins) - 192;
    if (v >= 32) v = v - 64;
    return 8'(v);
  endfunction

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ins;
    int         ack_wait;
    int         rdy_wait;
    logic       ob;
    logic [7:0] off;
  } vec_t;

  vec_t vecs [10];

  logic [7:0] memory [256];
  logic [7:0] pc, hold_ins, hold_pc, p_data, p_addr;
  logic       p_ack, p_disc, p_accept, p_flush_hold, p_step, req_flushed, captured;
  int         wait_cnt, idle_cyc, accepted;

  initial begin
    areset = 1'b0; pc_addr = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
    ir_ready = 1'b0; flush = 1'b0;

    vecs[0] = '{8'h00, 8'h12, 0, 0, 1'b0, 8'h00};
    vecs[1] = '{8'h10, 8'hFE, 0, 0, 1'b1, 8'hFE};
    vecs[2] = '{8'h11, 8'hC5, 1, 0, 1'b1, 8'h05};
    vecs[3] = '{8'h20, 8'hE0, 3, 0, 1'b1, 8'hE0};
    vecs[4] = '{8'h30, 8'hBF, 0, 5, 1'b0, 8'h00};
    vecs[5] = '{8'h40, 8'hFF, 2, 1, 1'b1, 8'hFF};
    vecs[6] = '{8'h50, 8'hC0, 0, 0, 1'b1, 8'h00};
    vecs[7] = '{8'hFF, 8'hDF, 0, 2, 1'b1, 8'h1F};
    vecs[8] = '{8'h80, 8'h7F, 1, 1, 1'b0, 8'h00};
    vecs[9] = '{8'h81, 8'hA0, 0, 0, 1'b0, 8'h00};

    // Reset state, held and after release (IDLE).
    tick; tick;
    chk_zero("rst_hold");
    areset = 1'b1;
    chk_zero("rst_idle");

    // Table: one full instruction per vector with given wait states.
    for (int i = 0; i < 10; i++) begin
      pc_addr = vecs[i].pc;
      tick;
      chk("v_req",      32'(mem_req),    32'd1);
      chk("v_addr",     32'(mem_addr),   32'(vecs[i].pc));
      chk("v_step_clr", 32'({pc_step, offset_bit, offset}), 32'd0);
      chk("v_nvalid",   32'(ir_valid),   32'd0);
      for (int w = 0; w < vecs[i].ack_wait; w++) begin
        mem_rdata = 8'h5A;
        tick;
        chk("v_req_wait",  32'(mem_req),  32'd1);
        chk("v_addr_wait", 32'(mem_addr), 32'(vecs[i].pc));
        chk("v_nvalid_wait", 32'(ir_valid), 32'd0);
      end
      mem_ack = 1'b1; mem_rdata = vecs[i].ins;
      tick;
      mem_ack = 1'b0; mem_rdata = 8'h00;
      chk("v_valid",   32'(ir_valid), 32'd1);
      chk("v_ir_data", 32'(ir_data),  32'(vecs[i].ins));
      chk("v_ir_pc",   32'(ir_pc),    32'(vecs[i].pc));
      chk("v_req_off", 32'(mem_req),  32'd0);
      for (int r = 0; r < vecs[i].rdy_wait; r++) begin
        tick;
        chk("v_hold_valid", 32'(ir_valid), 32'd1);
        chk("v_hold_data",  32'(ir_data),  32'(vecs[i].ins));
        chk("v_hold_nstep", 32'(pc_step),  32'd0);
        chk("v_hold_noreq", 32'(mem_req),  32'd0);
      end
      ir_ready = 1'b1;
      tick;
      ir_ready = 1'b0;
      chk("v_step",       32'(pc_step),    32'd1);
      chk("v_offset_bit", 32'(offset_bit), 32'(vecs[i].ob));
      chk("v_offset",     32'(offset),     32'(vecs[i].off));
      chk("v_step_nvalid", 32'(ir_valid),  32'd0);
    end

    // Flush while a request is pending: acked word dropped, same PC refetched.
    pc_addr = 8'h44;
    tick;
    chk("fl_req", 32'(mem_req), 32'd1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_req_held", 32'(mem_req), 32'd1);
    chk("fl_addr_held", 32'(mem_addr), 32'h44);
    tick;
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick;
    mem_ack = 1'b0;
    chk("fl_dropped", 32'(ir_valid), 32'd0);
    chk("fl_rereq",   32'(mem_req),  32'd1);
    chk("fl_readdr",  32'(mem_addr), 32'h44);
    mem_ack = 1'b1; mem_rdata = 8'h21;
    tick;
    mem_ack = 1'b0;
    chk("fl_cap_valid", 32'(ir_valid), 32'd1);
    chk("fl_cap_data",  32'(ir_data),  32'h21);
    chk("fl_cap_pc",    32'(ir_pc),    32'h44);

    // Flush and ready together in HOLD: flush wins, no PC step.
    flush = 1'b1; ir_ready = 1'b1;
    tick;
    flush = 1'b0; ir_ready = 1'b0;
    chk("fh_nstep",  32'(pc_step),  32'd0);
    chk("fh_nvalid", 32'(ir_valid), 32'd0);
    chk("fh_req",    32'(mem_req),  32'd1);
    chk("fh_addr",   32'(mem_addr), 32'h44);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    ir_ready = 1'b1;
    tick;
    ir_ready = 1'b0;
    chk("fh_step", 32'(pc_step), 32'd1);

    // Flush during STEP is ignored; next fetch proceeds normally.
    flush = 1'b1; pc_addr = 8'h45;
    tick;
    flush = 1'b0;
    chk("fs_req",  32'(mem_req),  32'd1);
    chk("fs_addr", 32'(mem_addr), 32'h45);

    // Asynchronous reset mid-FETCH clears outputs without a clock edge.
    tick;
    #2;
    areset = 1'b0;
    #1;
    chk_zero("arst_now");
    tick;
    chk_zero("arst_held");
    areset = 1'b1;
    chk("arst_idle", 32'(mem_req), 32'd0);
    tick;
    chk("arst_fetch", 32'(mem_req),  32'd1);
    chk("arst_addr",  32'(mem_addr), 32'h45);

    // Randomized run against a transaction-level model with a PC model.
    for (int k = 0; k < 256; k++) memory[k] = 8'($urandom);
    areset = 1'b0; flush = 1'b0; ir_ready = 1'b0; mem_ack = 1'b0;
    tick; tick;
    areset = 1'b1;
    pc = 8'h00; pc_addr = pc;
    p_ack = 1'b0; p_disc = 1'b0; p_accept = 1'b0; p_flush_hold = 1'b0; p_step = 1'b0;
    req_flushed = 1'b0; hold_ins = 8'h00; hold_pc = 8'h00; p_data = 8'h00; p_addr = 8'h00;
    wait_cnt = int'($urandom_range(0, 3)); idle_cyc = 0; accepted = 0;

    for (int c = 0; c < 3000; c++) begin
      tick;
      captured = p_ack && !p_disc;
      if (captured) begin
        chk("r_cap_valid", 32'(ir_valid), 32'd1);
        chk("r_cap_data",  32'(ir_data),  32'(p_data));
        chk("r_cap_pc",    32'(ir_pc),    32'(p_addr));
        hold_ins = p_data; hold_pc = p_addr;
      end
      if (p_ack && p_disc) begin
        chk("r_disc_nvalid", 32'(ir_valid), 32'd0);
        chk("r_disc_req",    32'(mem_req),  32'd1);
        chk("r_disc_addr",   32'(mem_addr), 32'(pc));
      end
      chk("r_pc_step", 32'(pc_step), 32'(p_accept));
      if (p_accept) begin
        chk("r_offset_bit", 32'(offset_bit), 32'(ref_branch(hold_ins)));
        chk("r_offset",     32'(offset),     32'(ref_offset(hold_ins)));
        chk("r_step_nvalid", 32'(ir_valid),  32'd0);
        if (ref_branch(hold_ins)) pc = pc + ref_offset(hold_ins);
        else                      pc = pc + 8'd1;
        pc_addr = pc;
        accepted++;
        idle_cyc = 0;
      end
      if (p_flush_hold) begin
        chk("r_fh_nvalid", 32'(ir_valid), 32'd0);
        chk("r_fh_req",    32'(mem_req),  32'd1);
        chk("r_fh_addr",   32'(mem_addr), 32'(pc));
      end
      if (p_step) begin
        chk("r_after_step_req",  32'(mem_req),  32'd1);
        chk("r_after_step_addr", 32'(mem_addr), 32'(pc));
      end
      if (ir_valid && !captured) begin
        chk("r_hold_data", 32'(ir_data), 32'(hold_ins));
        chk("r_hold_pc",   32'(ir_pc),   32'(hold_pc));
      end
      if (mem_req) chk("r_req_addr", 32'(mem_addr), 32'(pc));
      chk("r_exclusive", 32'((int'(mem_req) + int'(ir_valid) + int'(pc_step)) > 1), 32'd0);
      p_step = p_accept;

      // Drive this cycle's inputs and record what the model expects next.
      flush     = ($urandom_range(0, 9) == 0);
      ir_ready  = ($urandom_range(0, 3) != 0);
      mem_rdata = 8'($urandom);
      mem_ack   = 1'b0;
      p_ack     = 1'b0;
      p_disc    = 1'b0;
      if (mem_req) begin
        if (flush) req_flushed = 1'b1;
        if (wait_cnt == 0) begin
          mem_ack     = 1'b1;
          mem_rdata   = memory[mem_addr];
          p_ack       = 1'b1;
          p_disc      = req_flushed;
          p_data      = memory[pc];
          p_addr      = pc;
          req_flushed = 1'b0;
          wait_cnt    = int'($urandom_range(0, 3));
          idle_cyc    = 0;
        end else begin
          wait_cnt--;
        end
      end
      p_accept     = ir_valid && ir_ready && !flush;
      p_flush_hold = ir_valid && flush;
      idle_cyc++;
      if (idle_cyc > 40) begin
        chk("r_watchdog", 32'(idle_cyc), 32'd0);
        break;
      end
    end
    chk("r_progress", 32'(accepted > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
